// File: rtl/requant_scaler.sv
// rtl/requant_scaler.sv - two-stage requantising scaler with saturation and cell index tagging
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cfg_load        latch cfg_scale / cfg_shift / cfg_offset at this edge
//   cfg_scale       unsigned multiplier
//   cfg_shift       arithmetic right-shift applied after multiply (and rounding)
//   cfg_offset      signed offset added after the shift
//   input_result    {valid, result}; accepted when valid & input_ready
//   input_ready     upstream may present a new result
//   output_ready    downstream accepts the current output
//   output_value    clamped result, 0 .. 2^DATA_WIDTH-1
//   output_index    wrapping cell index 0 .. CELL_AMOUNT-1
//   output_last     output_index == CELL_AMOUNT-1
//   output_enable   output valid
module requant_scaler #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16,
  parameter int INDEX_WIDTH  = 10,
  parameter int SCALE_WIDTH  = 16,
  parameter int SHIFT_WIDTH  = 5,
  parameter int CELL_AMOUNT  = 4,
  parameter int SIGNED_INPUT = 0,
  parameter int ROUND        = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_load,
  input  logic [SCALE_WIDTH-1:0]  cfg_scale,
  input  logic [SHIFT_WIDTH-1:0]  cfg_shift,
  input  logic [DATA_WIDTH:0]     cfg_offset,
  input  logic [RESULT_WIDTH:0]   input_result,
  output logic                    input_ready,
  input  logic                    output_ready,
  output logic [DATA_WIDTH-1:0]   output_value,
  output logic [INDEX_WIDTH-1:0]  output_index,
  output logic                    output_last,
  output logic                    output_enable
);

  // Product holds result*scale without overflow for either input signedness.
  localparam int PROD_W = RESULT_WIDTH + SCALE_WIDTH + 1;
  // One extra bit so the rounding increment cannot wrap the product.
  localparam int RND_W  = PROD_W + 1;
  // One more bit so adding the offset cannot wrap either.
  localparam int SUM_W  = RND_W + 1;

  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(CELL_AMOUNT - 1);

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  logic [SCALE_WIDTH-1:0] scale_q;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH:0]    offset_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scale_q  <= SCALE_WIDTH'(1);
      shift_q  <= '0;
      offset_q <= '0;
    end else if (cfg_load) begin
      scale_q  <= cfg_scale;
      shift_q  <= cfg_shift;
      offset_q <= cfg_offset;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic in_valid;
  logic [RESULT_WIDTH-1:0] in_data;
  logic s1_valid;
  logic s2_valid;
  logic s2_load;

  assign in_valid = input_result[RESULT_WIDTH];
  assign in_data  = input_result[RESULT_WIDTH-1:0];

  // Stage 2 takes a new entry when it is empty or its current entry leaves.
  assign s2_load     = !s2_valid || output_ready;
  // Stage 1 can accept when it is empty or moving forward this cycle.
  assign input_ready = !s1_valid || s2_load;

  // ---------------------------------------------------------------------------
  // Stage 1: multiply, snapshot shift/offset alongside the product
  // ---------------------------------------------------------------------------
  logic signed [PROD_W-1:0] res_ext;
  logic signed [PROD_W-1:0] scale_ext;
  logic signed [PROD_W-1:0] prod;

  generate
    if (SIGNED_INPUT != 0) begin : g_sext
      assign res_ext = {{(PROD_W-RESULT_WIDTH){in_data[RESULT_WIDTH-1]}}, in_data};
    end else begin : g_zext
      assign res_ext = {{(PROD_W-RESULT_WIDTH){1'b0}}, in_data};
    end
  endgenerate

  assign scale_ext = {{(PROD_W-SCALE_WIDTH){1'b0}}, scale_q};
  assign prod      = res_ext * scale_ext;

  logic signed [PROD_W-1:0] s1_prod;
  logic [SHIFT_WIDTH-1:0]   s1_shift;
  logic [DATA_WIDTH:0]      s1_offset;

  // The config registers are read here before their own update lands, so a
  // result accepted on a cfg_load cycle still uses the old configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_prod   <= '0;
      s1_shift  <= '0;
      s1_offset <= '0;
    end else if (input_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_prod   <= prod;
        s1_shift  <= shift_q;
        s1_offset <= offset_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 datapath: round, shift, offset, clamp
  // ---------------------------------------------------------------------------
  logic signed [RND_W-1:0] rnd_add;
  logic signed [RND_W-1:0] rounded;
  logic signed [RND_W-1:0] shifted;
  logic signed [SUM_W-1:0] summed;
  logic [DATA_WIDTH-1:0]   clamped;

  always_comb begin
    rnd_add = '0;
    if (ROUND != 0 && s1_shift != '0) begin
      rnd_add = RND_W'(1) << (s1_shift - SHIFT_WIDTH'(1));
    end
  end

  assign rounded = {s1_prod[PROD_W-1], s1_prod} + rnd_add;
  // Arithmetic shift: any shift past the width leaves only sign bits (0 or -1).
  assign shifted = rounded >>> s1_shift;
  assign summed  = {{(SUM_W-RND_W){shifted[RND_W-1]}}, shifted}
                 + {{(SUM_W-DATA_WIDTH-1){s1_offset[DATA_WIDTH]}}, s1_offset};

  always_comb begin
    clamped = summed[DATA_WIDTH-1:0];
    if (summed[SUM_W-1]) begin
      clamped = '0;
    end else if (|summed[SUM_W-2:DATA_WIDTH]) begin
      clamped = '1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 registers and wrapping cell index
  // ---------------------------------------------------------------------------
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [DATA_WIDTH-1:0]  s2_value;
  logic [INDEX_WIDTH-1:0] s2_index;
  logic                   s2_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_value <= '0;
      s2_index <= '0;
      s2_last  <= 1'b0;
      idx_q    <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_value <= clamped;
        s2_index <= idx_q;
        s2_last  <= (idx_q == LAST_INDEX);
        idx_q    <= (idx_q == LAST_INDEX) ? '0 : idx_q + INDEX_WIDTH'(1);
      end
    end
  end

  // Outputs read as zero whenever nothing valid is presented.
  assign output_enable = s2_valid;
  assign output_value  = s2_valid ? s2_value : '0;
  assign output_index  = s2_valid ? s2_index : '0;
  assign output_last   = s2_valid & s2_last;

endmodule

// File: tb/tb_requant_scaler.sv
// tb/tb_requant_scaler.sv - directed self-checking bench for requant_scaler
module tb_requant_scaler;

  logic        clk;
  logic        rst;
  logic        cfg_load;
  logic [15:0] cfg_scale;
  logic [4:0]  cfg_shift;
  logic [8:0]  cfg_offset;
  logic [16:0] input_result;
  logic        output_ready;

  logic       ir_d, en_d, last_d;
  logic [7:0] val_d;
  logic [9:0] idx_d;
  logic       ir_t, en_t, last_t;
  logic [7:0] val_t;
  logic [9:0] idx_t;
  logic       ir_s, en_s, last_s;
  logic [7:0] val_s;
  logic [9:0] idx_s;

  int checks;
  int errors;

  requant_scaler u_def (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_scale(cfg_scale),
    .cfg_shift(cfg_shift), .cfg_offset(cfg_offset), .input_result(input_result),
    .input_ready(ir_d), .output_ready(output_ready), .output_value(val_d),
    .output_index(idx_d), .output_last(last_d), .output_enable(en_d)
  );

  requant_scaler #(.ROUND(0)) u_trunc (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_scale(cfg_scale),
    .cfg_shift(cfg_shift), .cfg_offset(cfg_offset), .input_result(input_result),
    .input_ready(ir_t), .output_ready(output_ready), .output_value(val_t),
    .output_index(idx_t), .output_last(last_t), .output_enable(en_t)
  );

  requant_scaler #(.SIGNED_INPUT(1)) u_sgn (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_scale(cfg_scale),
    .cfg_shift(cfg_shift), .cfg_offset(cfg_offset), .input_result(input_result),
    .input_ready(ir_s), .output_ready(output_ready), .output_value(val_s),
    .output_index(idx_s), .output_last(last_s), .output_enable(en_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full output check of the default instance.
  task automatic chk_d(input string tag, input int v, input int i, input logic l);
    chk({tag, ".en"}, 32'(en_d), 32'd1);
    chk({tag, ".val"}, 32'(val_d), 32'(v));
    chk({tag, ".idx"}, 32'(idx_d), 32'(i));
    chk({tag, ".last"}, 32'(last_d), 32'(l));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [15:0] v);
    input_result = {1'b1, v};
    tick();
    input_result = '0;
    tick();
  endtask

  task automatic load_cfg(input logic [15:0] sc, input logic [4:0] sh, input logic [8:0] of);
    cfg_load   = 1'b1;
    cfg_scale  = sc;
    cfg_shift  = sh;
    cfg_offset = of;
    tick();
    cfg_load = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    cfg_load     = 1'b0;
    cfg_scale    = '0;
    cfg_shift    = '0;
    cfg_offset   = '0;
    input_result = '0;
    output_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst.en", 32'(en_d), 32'd0);
    chk("rst.val", 32'(val_d), 32'd0);
    chk("rst.idx", 32'(idx_d), 32'd0);
    chk("rst.last", 32'(last_d), 32'd0);
    chk("rst.in_ready", 32'(ir_d), 32'd1);
    chk("rst.en_trunc", 32'(en_t), 32'd0);

    // Default config, back-to-back stream with saturation
    input_result = {1'b1, 16'd0};
    tick();
    chk("b2b.latency_en", 32'(en_d), 32'd0);
    input_result = {1'b1, 16'd7};
    tick();
    chk_d("b2b0", 0, 0, 1'b0);
    input_result = {1'b1, 16'd255};
    tick();
    chk_d("b2b1", 7, 1, 1'b0);
    input_result = {1'b1, 16'd256};
    tick();
    chk_d("b2b2", 255, 2, 1'b0);
    input_result = '0;
    tick();
    chk_d("b2b3_sat", 255, 3, 1'b1);
    tick();
    chk("b2b.drain_en", 32'(en_d), 32'd0);
    chk("b2b.drain_val", 32'(val_d), 32'd0);

    // Scale/shift with and without rounding
    load_cfg(16'd3, 5'd1, 9'd0);
    send_one(16'd5);
    chk_d("rnd_7p5", 8, 0, 1'b0);
    chk("trunc_7p5", 32'(val_t), 32'd7);
    load_cfg(16'd19661, 5'd15, 9'd0);
    send_one(16'd100);
    chk_d("frac_100", 60, 1, 1'b0);
    chk("trunc_frac_100", 32'(val_t), 32'd60);

    // Signed input with positive and negative offset
    load_cfg(16'd1, 5'd0, 9'd10);
    send_one(16'hFFFB);
    chk("sgn_m5.val", 32'(val_s), 32'd5);
    chk("sgn_m5.idx", 32'(idx_s), 32'd2);
    chk("uns_fffb_sat", 32'(val_d), 32'd255);
    send_one(16'hFF9C);
    chk("sgn_m100_clamp", 32'(val_s), 32'd0);
    chk("sgn_m100.last", 32'(last_s), 32'd1);
    load_cfg(16'd1, 5'd0, 9'h1FD);
    send_one(16'd2);
    chk("sgn_negoff_clamp", 32'(val_s), 32'd0);
    chk_d("uns_negoff_clamp", 0, 0, 1'b0);

    // cfg_load coinciding with an accepted result
    input_result = {1'b1, 16'd20};
    cfg_load     = 1'b1;
    cfg_scale    = 16'd2;
    cfg_shift    = 5'd0;
    cfg_offset   = 9'd0;
    tick();
    cfg_load     = 1'b0;
    input_result = {1'b1, 16'd20};
    tick();
    chk_d("cfg_same_cycle_old", 17, 1, 1'b0);
    input_result = '0;
    tick();
    chk_d("cfg_next_new", 40, 2, 1'b0);
    send_one(16'd0);
    chk_d("filler", 0, 3, 1'b1);

    // Stream of six with a three-cycle output stall
    load_cfg(16'd1, 5'd0, 9'd0);
    input_result = {1'b1, 16'd10};
    tick();
    input_result = {1'b1, 16'd11};
    tick();
    chk_d("stall_o0", 10, 0, 1'b0);
    input_result = {1'b1, 16'd12};
    tick();
    chk_d("stall_o1", 11, 1, 1'b0);
    output_ready = 1'b0;
    input_result = {1'b1, 16'd13};
    #1;
    chk("stall.in_ready_low0", 32'(ir_d), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_d("stall_hold", 11, 1, 1'b0);
      if (k == 2) output_ready = 1'b1;
      #1;
      chk("stall.in_ready", 32'(ir_d), (k == 2) ? 32'd1 : 32'd0);
    end
    tick();
    chk_d("stall_o2", 12, 2, 1'b0);
    input_result = {1'b1, 16'd14};
    tick();
    chk_d("stall_o3", 13, 3, 1'b1);
    input_result = {1'b1, 16'd15};
    tick();
    chk_d("stall_o4", 14, 0, 1'b0);
    input_result = '0;
    tick();
    chk_d("stall_o5", 15, 1, 1'b0);
    tick();
    chk("stall.drain_en", 32'(en_d), 32'd0);

    // Reset with both stages full and output stalled
    load_cfg(16'd5, 5'd0, 9'd0);
    output_ready = 1'b0;
    input_result = {1'b1, 16'd50};
    tick();
    input_result = {1'b1, 16'd51};
    tick();
    chk_d("full_before_rst", 250, 2, 1'b0);
    #1;
    chk("full.in_ready", 32'(ir_d), 32'd0);
    rst          = 1'b1;
    input_result = '0;
    tick();
    rst = 1'b0;
    chk("midrst.en", 32'(en_d), 32'd0);
    chk("midrst.val", 32'(val_d), 32'd0);
    chk("midrst.idx", 32'(idx_d), 32'd0);
    chk("midrst.last", 32'(last_d), 32'd0);
    chk("midrst.in_ready", 32'(ir_d), 32'd1);
    output_ready = 1'b1;
    send_one(16'd50);
    chk_d("post_rst_cfg_idx", 50, 0, 1'b0);
    tick();
    chk("post_rst.discarded", 32'(en_d), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
